// File: rtl/os_drain_collector.sv
// ---------------------------------------------------------------------------
// os_drain_collector
//   Collects the N result words that leave the bottom PE of an output-
//   stationary column drain chain. Each captured word is tagged with its
//   drain index and a last flag, and is then pushed into a show-ahead FIFO
//   of DEPTH entries. The consumer drains that FIFO independently of the
//   capture FSM.
//
// Ports
//   clk, rst_n        single clock; asynchronous active-low reset
//   drain_start       one-cycle pulse that arms one drain (taken only in IDLE)
//   in_data/in_valid  result word and stage-valid from the bottom PE
//   out_data/out_valid/out_ready
//                     show-ahead head of the FIFO; pops on valid && ready
//   out_last          head word is word N-1 of its drain
//   out_idx           drain index of the head word
//   busy              FSM is ARMED or CAPTURE
//   done              one-cycle pulse in the cycle after the Nth capture
//   overflow          sticky; a captured word was dropped because the FIFO
//                     was full. Cleared when the next drain is armed.
// ---------------------------------------------------------------------------
module os_drain_collector #(
  parameter int D_W   = 8,
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  drain_start,
  input  logic [2*D_W-1:0]                      in_data,
  input  logic                                  in_valid,
  output logic [2*D_W-1:0]                      out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  out_idx,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  // Widths: IW holds a drain index, AW addresses the storage array, PW is
  // the pointer width with one extra wrap bit so full and empty differ.
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int AWS = (AW > 0) ? AW : 1;
  localparam int PW  = AW + 1;
  localparam int DW  = 2 * D_W;
  localparam int EW  = DW + IW + 1;

  // Pointer XOR pattern meaning "same slot, opposite lap": only the wrap bit
  // differs.
  localparam logic [PW-1:0] WRAP_BIT = PW'(1) << AW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt;

  // Capture-side decode, produced by the FSM output process.
  logic          start;
  logic          cap;
  logic          cap_last;

  // FIFO
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [AWS-1:0] wa, ra;
  logic          empty, full;
  logic          pop, push_ok, push_drop;
  logic [EW-1:0] head;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  //   No timeout: ARMED/CAPTURE wait as long as in_valid stays low.
  //   cnt is 0 while ARMED, so cap_last in ARMED means N == 1.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain_start) state_nxt = ARMED;
      end
      ARMED: begin
        if (in_valid) state_nxt = cap_last ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (in_valid && cap_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs / capture decode
  // -------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    start    = 1'b0;
    cap      = 1'b0;
    cap_last = (cnt == LAST_IDX);
    case (state)
      IDLE: begin
        start = drain_start;
      end
      ARMED, CAPTURE: begin
        busy = 1'b1;
        cap  = in_valid;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Capture counter, done pulse, sticky overflow
  //   The counter advances on every capture, including a dropped one, so the
  //   indices of the words that do get through remain correct.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= cap & cap_last;
      if (start) begin
        cnt      <= '0;
        overflow <= 1'b0;
      end else begin
        if (cap) cnt <= cap_last ? '0 : cnt + IW'(1);
        if (push_drop) overflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO control
  //   A push into a full FIFO is still accepted when the head is popped in
  //   the same cycle, because that pop frees the slot the push writes.
  // -------------------------------------------------------------------------
  assign empty     = (wp == rp);
  assign full      = ((wp ^ rp) == WRAP_BIT);
  assign pop       = ~empty & out_ready;
  assign push_ok   = cap & (~full | pop);
  assign push_drop = cap & full & ~pop;

  assign wa = AWS'(wp % PW'(DEPTH));
  assign ra = AWS'(rp % PW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + PW'(push_ok);
      rp <= rp + PW'(pop);
    end
  end

  // Storage has no reset. The read side is masked by out_valid, so the stale
  // contents of the array are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wa] <= {in_data, cnt, cap_last};
  end

  // -------------------------------------------------------------------------
  // Show-ahead read side. The outputs are zero while the FIFO is empty, and
  // therefore also as soon as reset clears the pointers.
  // -------------------------------------------------------------------------
  assign head      = mem[ra];
  assign out_valid = ~empty;
  assign out_data  = out_valid ? head[EW-1 -: DW] : '0;
  assign out_idx   = out_valid ? head[IW:1]       : '0;
  assign out_last  = out_valid & head[0];

endmodule

// File: tb/tb_os_drain_collector.sv
// ---------------------------------------------------------------------------
// tb_os_drain_collector
//   Scoreboard bench. A queue-level reference model, clocked with the DUT,
//   pushes every word that should land in the buffer into the scoreboard.
//   It also tracks occupancy, busy, done and overflow. A negedge monitor
//   pops the scoreboard whenever the DUT hands over a word (out_valid &&
//   out_ready), compares that word, and checks the status outputs against
//   the model every cycle. The stimulus is a set of directed drains followed
//   by a randomized phase.
// ---------------------------------------------------------------------------
module tb_os_drain_collector;

  localparam int D_W   = 8;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            drain_start = 1'b0;
  logic [15:0]     in_data = '0;
  logic            in_valid = 1'b0;
  logic [15:0]     out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic [IW-1:0]   out_idx;
  logic            busy;
  logic            done;
  logic            overflow;

  os_drain_collector #(.D_W(D_W), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .drain_start(drain_start),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] d;
    int          idx;
    bit          last;
  } ent_t;

  ent_t sb[$];
  bit   m_armed = 0;
  int   m_next  = 0;
  int   m_occ   = 0;
  bit   m_ovf   = 0;
  bit   m_done  = 0;

  always @(posedge clk or negedge rst_n) begin
    bit p, lst;
    if (!rst_n) begin
      m_armed = 0; m_next = 0; m_occ = 0; m_ovf = 0; m_done = 0;
      sb.delete();
    end else begin
      p = (m_occ > 0) && out_ready;
      m_done = 0;
      if (!m_armed) begin
        if (drain_start) begin
          m_armed = 1; m_next = 0; m_ovf = 0;
        end
      end else if (in_valid) begin
        lst = (m_next == N - 1);
        if (m_occ - int'(p) < DEPTH) begin
          sb.push_back('{in_data, m_next, lst});
          m_occ++;
        end else begin
          m_ovf = 1;
        end
        if (lst) begin
          m_armed = 0; m_done = 1;
        end else begin
          m_next++;
        end
      end
      if (p) m_occ--;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      chk("out_valid", out_valid, m_occ > 0);
      chk("busy", busy, m_armed);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pop_unexpected: got word %0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_idx", out_idx, e.idx);
          chk("out_last", out_last, e.last);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit ds, input bit iv, input logic [15:0] d, input bit rdy);
    drain_start = ds; in_valid = iv; in_data = d; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_idx"},   out_idx,   0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_overflow"},  overflow,  0);
  endtask

  task automatic basic_drain(input bit rdy);
    drive(1, 0, 16'h0, rdy);
    drive(0, 1, 16'h0011, rdy);
    drive(0, 1, 16'h0022, rdy);
    drive(0, 1, 16'h0033, rdy);
    drive(0, 1, 16'h0044, rdy);
  endtask

  initial begin
    bit gap [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [15:0] gd;
    #2;
    chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 16'h0, 1);

    // Single drain with an always-ready consumer.
    basic_drain(1);
    repeat (4) drive(0, 0, 16'h0, 1);

    // Drain with in_valid gaps.
    drive(1, 0, 16'h0, 1);
    gd = 16'h0100;
    foreach (gap[i]) begin
      drive(0, gap[i], gd, 1);
      if (gap[i]) gd = gd + 16'h0101;
    end
    repeat (3) drive(0, 0, 16'h0, 1);

    // Three drains into a stalled consumer, then re-arm, then push and pop
    // at the same time while full.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 16'h0, 0);
      for (int j = 0; j < 4; j++) drive(0, 1, 16'(16'h1000 + k * 16 + j), 0);
    end
    repeat (2) drive(0, 0, 16'h0, 0);
    drive(1, 0, 16'h0, 0);
    for (int j = 0; j < 4; j++) drive(0, 1, 16'(16'h2000 + j), 1);
    repeat (10) drive(0, 0, 16'h0, 1);

    // in_valid ignored in IDLE; drain_start ignored while capturing.
    repeat (3) drive(0, 1, 16'hDEAD, 1);
    drive(1, 0, 16'h0, 1);
    drive(0, 1, 16'h3000, 1);
    drive(1, 0, 16'h0, 1);
    drive(1, 1, 16'h3001, 1);
    drive(0, 1, 16'h3002, 1);
    drive(1, 1, 16'h3003, 1);
    repeat (3) drive(0, 0, 16'h0, 1);

    // Reset in the middle of a drain, with buffered words.
    drive(1, 0, 16'h0, 0);
    drive(0, 1, 16'h00A1, 0);
    drive(0, 1, 16'h00A2, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 16'h0, 1);
    basic_drain(1);
    repeat (4) drive(0, 0, 16'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(1) == 1, 16'($urandom),
            (i % 150 < 40) ? ($urandom_range(5) == 0) : ($urandom_range(3) != 0));
    end
    repeat (20) drive(0, 0, 16'h0, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/os_drain_collector.md
OS_DRAIN_COLLECTOR -- requirements
Module: os_drain_collector

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- D_W, 8, PE operand width; result width is 2*D_W.
- N, 4, results drained per column per drain; N >= 1.
- DEPTH, 8, buffer entries; power of 2, DEPTH >= N.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- drain_start, in, 1, single-cycle pulse that arms one drain.
- in_data, in, 2*D_W, result word from the bottom PE of the column drain chain.
- in_valid, in, 1, stage-valid from the bottom PE; qualifies in_data.
- out_data, out, 2*D_W, head-of-buffer result word.
- out_valid, out, 1, buffer non-empty.
- out_ready, in, 1, downstream accepts the head word.
- out_last, out, 1, head word is word N-1 of its drain.
- out_idx, out, max(1,$clog2(N)), drain index 0..N-1 of the head word.
- busy, out, 1, FSM not IDLE.
- done, out, 1, one-cycle pulse after the Nth capture.
- overflow, out, 1, sticky; a captured word was dropped.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, ARMED, CAPTURE.
REQ-004 IDLE + drain_start=1 SHALL go to ARMED next cycle and clear overflow and the capture counter.
REQ-005 ARMED + in_valid=1 SHALL capture in_data as index 0 and go to CAPTURE; if N==1, go to IDLE instead.
REQ-006 CAPTURE + in_valid=1 SHALL capture in_data with index = counter value, then increment the counter.
REQ-007 Capture of index N-1 SHALL tag the entry last=1, return to IDLE and pulse done for exactly one cycle in the following cycle.
REQ-008 in_valid=0 in ARMED/CAPTURE SHALL hold state and counter; there is no timeout.
REQ-009 in_valid in IDLE SHALL be ignored: no capture, no flag.
REQ-010 drain_start outside IDLE SHALL be ignored.
REQ-011 Capture SHALL push {in_data, idx, last} into a FIFO of DEPTH entries.
REQ-012 A push when the FIFO is full with no simultaneous pop SHALL drop the word and set overflow; the counter still advances.
REQ-013 Push and pop in the same cycle with the FIFO full SHALL accept the push; occupancy is unchanged and overflow stays clear.
REQ-014 Push and pop in the same cycle with the FIFO empty SHALL NOT occur, since out_valid=0 at that point; the pushed word becomes visible next cycle.
REQ-015 FIFO read side SHALL be show-ahead:
- out_valid = not empty.
- out_data, out_idx and out_last reflect the head entry.
- Pop on out_valid && out_ready.
REQ-016 Latency SHALL be exactly one cycle: a word captured at edge t is presented on out_valid/out_data after edge t when the FIFO was empty.
REQ-017 out_ready=1 with out_valid=0 SHALL have no effect.
REQ-018 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty SHALL be decoded from the MSB compare.
REQ-019 FIFO drain by the consumer SHALL continue independently of FSM state, including IDLE.
REQ-020 busy SHALL be 1 in ARMED and CAPTURE.

Reset
REQ-021 rst_n=0 SHALL asynchronously force:
- FSM to IDLE; counter to 0.
- FIFO empty (pointers 0).
- out_valid, out_last, out_idx, out_data, busy, done, overflow to 0.
REQ-022 Reset asserted mid-drain SHALL discard the partial drain and all buffered words; no done pulse follows.
REQ-023 Reset deassertion SHALL take effect on the next rising clk edge; the first drain_start is honoured on that edge or later.

Verification (D_W=8, N=4, DEPTH=8)
REQ-024 drain_start, then in_valid for 4 consecutive cycles with data 0x0011, 0x0022, 0x0033, 0x0044, out_ready=1 -> out_data matches each value one cycle later; out_idx 0..3; out_last only on 0x0044; done pulses once; busy falls.
REQ-025 Same drain with in_valid gaps (1,0,0,1,1,0,1) -> 4 words captured in order; FSM held in CAPTURE across the gaps; done after the 4th word.
REQ-026 out_ready=0 across three drains (12 pushes) -> 8 words buffered; overflow=1 after the 9th push; the next drain_start clears overflow.
REQ-027 FIFO full, then push and pop in the same cycle -> occupancy stays 8; popped word is the oldest; overflow=0.
REQ-028 rst_n pulsed low after 2 captures -> all outputs 0 immediately; no done pulse; a subsequent full drain behaves as in REQ-024.
REQ-029 in_valid pulses while IDLE, and drain_start pulses during CAPTURE -> no captures, no state change, counter unaffected.
